// File: rtl/piano_key_scan.sv
// rtl/piano_key_scan.sv - synchronise, debounce and priority-encode piano keys; octave up/down state
module piano_key_scan #(
    parameter int DEB_CYCLES = 20000,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_c,
    input  logic key_d,
    input  logic key_e,
    input  logic key_f,
    input  logic key_g,
    input  logic key_a,
    input  logic key_b,
    input  logic btn_up,
    input  logic btn_down,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g,
    output logic a,
    output logic b,
    output logic note_valid,
    output logic up,
    output logic down
);

    localparam int NIN = 9;
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW  = 2'd0,
        MID  = 2'd1,
        HIGH = 2'd2
    } octave_t;

    // Bit order: notes in priority order (c highest) in [6:0], up in [7], down in [8]
    logic [NIN-1:0]   raw;
    logic [NIN-1:0]   sync1;
    logic [NIN-1:0]   sync2;
    logic [NIN-1:0]   deb;
    logic [CNT_W-1:0] cnt [NIN];
    logic [6:0]       note_sel;
    logic [6:0]       note_q;
    logic             up_d;
    logic             down_d;
    logic             ev_up;
    logic             ev_down;
    octave_t          state;

    assign raw = {btn_down, btn_up, key_b, key_a, key_g, key_f, key_e, key_d, key_c};

    // Two-flop synchroniser for every raw input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-input debounce: a mismatch must persist DEB_CYCLES cycles before the debounced value follows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '0;
            for (int i = 0; i < NIN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_MAX) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Isolating the lowest set bit gives the highest-priority pressed note
    assign note_sel = deb[6:0] & (~deb[6:0] + 7'd1);

    // Registered one-hot note and its valid flag update together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_q     <= '0;
            note_valid <= 1'b0;
        end else begin
            note_q     <= note_sel;
            note_valid <= |deb[6:0];
        end
    end

    assign c = note_q[0];
    assign d = note_q[1];
    assign e = note_q[2];
    assign f = note_q[3];
    assign g = note_q[4];
    assign a = note_q[5];
    assign b = note_q[6];

    // Delayed copies of the debounced buttons for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_d   <= 1'b0;
            down_d <= 1'b0;
        end else begin
            up_d   <= deb[7];
            down_d <= deb[8];
        end
    end

    assign ev_up   = deb[7] & ~up_d;
    assign ev_down = deb[8] & ~down_d;

    // Octave FSM; saturating steps, simultaneous events cancel, outputs decode the previous state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MID;
            up    <= 1'b0;
            down  <= 1'b0;
        end else begin
            up   <= (state == HIGH);
            down <= (state == LOW);
            case (state)
                LOW: begin
                    if (ev_up && !ev_down) state <= MID;
                end
                MID: begin
                    if (ev_up && !ev_down)      state <= HIGH;
                    else if (ev_down && !ev_up) state <= LOW;
                end
                HIGH: begin
                    if (ev_down && !ev_up) state <= MID;
                end
                default: state <= MID;
            endcase
        end
    end

endmodule
